credit_sender: RTL and testbench
================================

CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning receiver buffer slots, which equals the initial credit count.
REQ-002 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH+1), meaning credit counter width.
REQ-004 SHALL have port re_clk  input  1  sender/receive-side clock; all logic is synchronous to it.
REQ-005 SHALL have port re_reset_n  input  1  reset: asynchronous, active-low; clock re_clk.
REQ-006 SHALL have port src_valid  input  1  upstream producer offers a word.
REQ-007 SHALL have port src_data  input  WIDTH  upstream word.
REQ-008 SHALL have port src_ready  output  1  sender accepts the word this cycle.
REQ-009 SHALL have port re_valid  output  1  word is driven to the receiving buffer this cycle.
REQ-010 SHALL have port data_out  output  WIDTH  word to the receiving buffer.
REQ-011 SHALL have port re_credit_pulse  input  1  one-cycle pulse, one per freed remote slot.
REQ-012 SHALL have port credits_avail  output  CNT_W  current credit count.
REQ-013 SHALL have port credit_err  output  1  sticky flag for credit overflow (protocol violation).

Function
REQ-014 SHALL hold a credit counter that is initialised to DEPTH and ranges from 0 to DEPTH.
REQ-015 SHALL drive src_ready combinationally as (credit count != 0) && (state != ERROR).
REQ-016 SHALL define fire as src_valid && src_ready; on fire, re_valid SHALL be 1 and data_out SHALL equal src_data at the next re_clk edge (1-cycle registered latency).
REQ-017 SHALL drive re_valid to 0 in any cycle following a non-fire cycle; data_out SHALL hold its last value.
REQ-018 SHALL update the credit count per cycle: fire only gives -1; pulse only gives +1; fire and pulse in the same cycle gives no change; neither gives no change.
REQ-019 SHALL treat a pulse with no fire while the count equals DEPTH as overflow: the count stays at DEPTH, credit_err is set, and the FSM enters ERROR.
REQ-020 SHALL implement FSM states SEND (count>0), BLOCKED (count==0) and ERROR.
REQ-021 SHALL implement FSM transitions: SEND->BLOCKED when the next count is 0; BLOCKED->SEND when a pulse arrives; any state->ERROR on overflow; ERROR exits only on reset.
REQ-022 In ERROR, the block SHALL drive src_ready=0 and re_valid=0, while the count continues to track pulses, saturating at DEPTH.
REQ-023 SHALL never assert re_valid more than DEPTH times without intervening pulses.
REQ-024 SHALL have credits_avail reflect the registered count, updated at the same edge as re_valid.

Reset
REQ-025 On re_reset_n low, the block SHALL set count=DEPTH, state=SEND, re_valid=0, data_out=0 and credit_err=0, all asynchronously.
REQ-026 SHALL ignore pulses and src_valid while in reset; after deassertion, the first fire SHALL be possible in the first re_clk cycle.
REQ-027 A reset that occurs mid-stream SHALL discard in-flight credit state; the receiver SHALL be reset alongside.

Configuration
REQ-028 With macro CREDIT_SENDER_STATS_EN defined, the block SHALL add output stat_sent[31:0] (fire count) and output stat_stall[31:0] (cycles with src_valid=1 and src_ready=0), both wrapping at 2^32 and both reset to 0.
REQ-029 Without CREDIT_SENDER_STATS_EN, neither port nor counter SHALL exist, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package credit_pkg SHALL hold the DEPTH/WIDTH defaults and the FSM state enum (SEND, BLOCKED, ERROR).
REQ-031 Sub-module credit_counter SHALL implement the count (inc, dec, saturation, overflow flag); credit_sender SHALL contain the FSM, the output register and the stats.

Verification
REQ-032 A bench SHALL cover: reset, then src_valid held at 1 for 20 cycles with no pulses -> exactly 16 re_valid cycles, credits_avail=0, src_ready=0 from cycle 17.
REQ-033 A bench SHALL cover: from count 0, a single pulse -> src_ready=1 the next cycle; one more word sent; count returns to 0.
REQ-034 A bench SHALL cover: count=5, with fire and pulse in the same cycle -> count stays at 5 and re_valid=1 the next cycle.
REQ-035 A bench SHALL cover: count=16, a pulse with no fire -> credit_err=1, src_ready=0, re_valid stays 0 until reset.
REQ-036 A bench SHALL cover: reset asserted mid-burst at count 7 -> re_valid=0 immediately, count=16, credit_err=0.
REQ-037 A bench SHALL cover, with CREDIT_SENDER_STATS_EN defined: 20 cycles of src_valid=1 from reset, no pulses -> stat_sent=16, stat_stall=4.

Source files
------------

// File: rtl/credit_pkg.sv
// credit_pkg: shared defaults and FSM state encoding for the credit sender.
//   DEPTH_DEF      - default receiver buffer depth (initial credit count)
//   WIDTH_DEF      - default data word width
//   credit_state_e - sender FSM states
package credit_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    SEND    = 2'd0,
    BLOCKED = 2'd1,
    ERROR   = 2'd2
  } credit_state_e;

endpackage

// File: rtl/credit_counter.sv
// credit_counter: saturating credit counter, starts full at DEPTH.
//   re_clk, re_reset_n - clock, async active-low reset
//   inc                - a remote slot was freed (credit return pulse)
//   dec                - a word was sent (never asserted while count is 0)
//   count              - registered credit count, 0..DEPTH
//   overflow           - credit return with no send while already full
import credit_pkg::*;

module credit_counter #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             re_clk,
  input  logic             re_reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  assign overflow = inc && !dec && (count == FULL);

  // Simultaneous inc and dec cancel; an overflowing inc leaves the count at FULL.
  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      count <= FULL;
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end else if (inc && !dec && (count != FULL)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/credit_sender.sv
// credit_sender: credit-based flow-control sender with a one-cycle
// registered output stage.
//   re_clk, re_reset_n    - clock, async active-low reset
//   src_valid/src_data    - upstream word offer
//   src_ready             - word accepted this cycle (combinational)
//   re_valid/data_out     - registered word to the receiving buffer
//   re_credit_pulse       - one pulse per freed remote slot
//   credits_avail         - registered credit count
//   credit_err            - sticky credit overflow flag
// Optional (macro CREDIT_SENDER_STATS_EN):
//   stat_sent             - number of words sent, wraps at 2^32
//   stat_stall            - cycles with src_valid=1 and src_ready=0, wraps
//
// state   | meaning
// SEND    | credits available, words may be sent
// BLOCKED | credit count is 0, waiting for a return pulse
// ERROR   | credit overflow seen, sending disabled until reset
import credit_pkg::*;

module credit_sender #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             re_clk,
  input  logic             re_reset_n,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic             re_valid,
  output logic [WIDTH-1:0] data_out,
  input  logic             re_credit_pulse,
  output logic [CNT_W-1:0] credits_avail,
  output logic             credit_err
`ifdef CREDIT_SENDER_STATS_EN
  ,
  output logic [31:0]      stat_sent,
  output logic [31:0]      stat_stall
`endif
);

  credit_state_e    state, state_nxt;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             fire;
  logic             going_empty;

  credit_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .re_clk     (re_clk),
    .re_reset_n (re_reset_n),
    .inc        (re_credit_pulse),
    .dec        (fire),
    .count      (count),
    .overflow   (overflow)
  );

  assign src_ready     = (count != '0) && (state != ERROR);
  assign fire          = src_valid && src_ready;
  assign credits_avail = count;

  // Last credit consumed with no return in the same cycle.
  assign going_empty = fire && !re_credit_pulse && (count == CNT_W'(1));

  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      state <= SEND;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (overflow) begin
      state_nxt = ERROR;
    end else begin
      case (state)
        SEND:    if (going_empty)     state_nxt = BLOCKED;
        BLOCKED: if (re_credit_pulse) state_nxt = SEND;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = ERROR;
      endcase
    end
  end

  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      re_valid   <= 1'b0;
      data_out   <= '0;
      credit_err <= 1'b0;
    end else begin
      re_valid <= fire;
      if (fire) begin
        data_out <= src_data;
      end
      if (overflow) begin
        credit_err <= 1'b1;
      end
    end
  end

`ifdef CREDIT_SENDER_STATS_EN
  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else begin
      if (fire) begin
        stat_sent <= stat_sent + 32'd1;
      end
      if (src_valid && !src_ready) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_credit_sender.sv
// tb_credit_sender: directed bench for credit_sender (DEPTH=16, WIDTH=32).
// Stats checks are compiled in when CREDIT_SENDER_STATS_EN is defined.
module tb_credit_sender;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             re_clk;
  logic             re_reset_n;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             src_ready;
  logic             re_valid;
  logic [WIDTH-1:0] data_out;
  logic             re_credit_pulse;
  logic [CNT_W-1:0] credits_avail;
  logic             credit_err;
`ifdef CREDIT_SENDER_STATS_EN
  logic [31:0]      stat_sent;
  logic [31:0]      stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  int valid_cnt;

  credit_sender #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .re_clk          (re_clk),
    .re_reset_n      (re_reset_n),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .re_valid        (re_valid),
    .data_out        (data_out),
    .re_credit_pulse (re_credit_pulse),
    .credits_avail   (credits_avail),
    .credit_err      (credit_err)
`ifdef CREDIT_SENDER_STATS_EN
    ,
    .stat_sent       (stat_sent),
    .stat_stall      (stat_stall)
`endif
  );

  initial re_clk = 1'b0;
  always #5 re_clk = ~re_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge re_clk);
    #1;
  endtask

  initial begin
    re_reset_n      = 1'b0;
    src_valid       = 1'b0;
    src_data        = '0;
    re_credit_pulse = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(re_valid), 32'd0);
    check("rst_credits", 32'(credits_avail), 32'd16);
    check("rst_err", 32'(credit_err), 32'd0);
    check("rst_data", data_out, 32'd0);
`ifdef CREDIT_SENDER_STATS_EN
    check("rst_stat_sent", stat_sent, 32'd0);
    check("rst_stat_stall", stat_stall, 32'd0);
`endif
    re_reset_n = 1'b1;

    // 20 cycles of src_valid with no returns: 16 words, then stall
    valid_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      src_valid = 1'b1;
      src_data  = 32'h100 + 32'(i);
      #1;
      check($sformatf("burst_ready_%0d", i), 32'(src_ready), (i < 16) ? 32'd1 : 32'd0);
      tick();
      if (re_valid) valid_cnt++;
      check($sformatf("burst_valid_%0d", i), 32'(re_valid), (i < 16) ? 32'd1 : 32'd0);
      if (i < 16) check($sformatf("burst_data_%0d", i), data_out, 32'h100 + 32'(i));
    end
    src_valid = 1'b0;
    check("burst_valid_cnt", 32'(valid_cnt), 32'd16);
    check("burst_credits", 32'(credits_avail), 32'd0);
    check("burst_data_hold", data_out, 32'h10f);
`ifdef CREDIT_SENDER_STATS_EN
    check("stat_sent", stat_sent, 32'd16);
    check("stat_stall", stat_stall, 32'd4);
`endif

    // Single return from empty: one more word, then empty again
    re_credit_pulse = 1'b1;
    tick();
    re_credit_pulse = 1'b0;
    check("ret1_credits", 32'(credits_avail), 32'd1);
    check("ret1_ready", 32'(src_ready), 32'd1);
    src_valid = 1'b1;
    src_data  = 32'hAA;
    tick();
    src_valid = 1'b0;
    check("ret1_valid", 32'(re_valid), 32'd1);
    check("ret1_data", data_out, 32'hAA);
    check("ret1_credits_end", 32'(credits_avail), 32'd0);
    check("ret1_ready_end", 32'(src_ready), 32'd0);
    tick();
    check("ret1_valid_drop", 32'(re_valid), 32'd0);

    // Build up to 5 credits, then fire and return in the same cycle
    re_credit_pulse = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    re_credit_pulse = 1'b0;
    check("c5_credits", 32'(credits_avail), 32'd5);
    src_valid       = 1'b1;
    src_data        = 32'h55;
    re_credit_pulse = 1'b1;
    tick();
    src_valid       = 1'b0;
    re_credit_pulse = 1'b0;
    check("c5_both_credits", 32'(credits_avail), 32'd5);
    check("c5_both_valid", 32'(re_valid), 32'd1);
    check("c5_both_data", data_out, 32'h55);

    // Fill to 16, then an extra return overflows
    re_credit_pulse = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("full_credits", 32'(credits_avail), 32'd16);
    check("full_err_pre", 32'(credit_err), 32'd0);
    tick();
    re_credit_pulse = 1'b0;
    check("ovf_err", 32'(credit_err), 32'd1);
    check("ovf_credits", 32'(credits_avail), 32'd16);
    check("ovf_ready", 32'(src_ready), 32'd0);
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ovf_valid_%0d", i), 32'(re_valid), 32'd0);
      check($sformatf("ovf_ready_%0d", i), 32'(src_ready), 32'd0);
    end
    src_valid = 1'b0;
    check("ovf_err_sticky", 32'(credit_err), 32'd1);

    // Reset clears the error
    re_reset_n = 1'b0;
    tick();
    re_reset_n = 1'b1;
    check("clr_err", 32'(credit_err), 32'd0);
    check("clr_ready", 32'(src_ready), 32'd1);

    // Mid-burst reset at count 7
    src_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      src_data = 32'h200 + 32'(i);
      tick();
    end
    check("mid_credits_pre", 32'(credits_avail), 32'd7);
    check("mid_valid_pre", 32'(re_valid), 32'd1);
    #2;
    re_reset_n = 1'b0;
    #1;
    check("mid_valid_rst", 32'(re_valid), 32'd0);
    check("mid_credits_rst", 32'(credits_avail), 32'd16);
    check("mid_err_rst", 32'(credit_err), 32'd0);
    check("mid_data_rst", data_out, 32'd0);
    tick();
    check("mid_valid_in_rst", 32'(re_valid), 32'd0);
    check("mid_credits_in_rst", 32'(credits_avail), 32'd16);
    re_reset_n = 1'b1;
    src_data   = 32'h3C;
    #1;
    check("post_rst_ready", 32'(src_ready), 32'd1);
    tick();
    src_valid = 1'b0;
    check("post_rst_valid", 32'(re_valid), 32'd1);
    check("post_rst_data", data_out, 32'h3C);
    check("post_rst_credits", 32'(credits_avail), 32'd15);
`ifdef CREDIT_SENDER_STATS_EN
    check("post_rst_stat_sent", stat_sent, 32'd1);
    check("post_rst_stat_stall", stat_stall, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
